// File: rtl/fixed_point_acc.sv
// -----------------------------------------------------------------------------
// fixed_point_acc
//
// Signed fixed-point accumulator placed behind the fixed-point multiplier.
// It sums NUM_TERMS consecutive products plus a bias, which is sampled with the
// first term. It then emits one saturated WIDTH-bit result per sequence.
// Input, bias and output words share one signed Qm.f format, so no rescaling
// is needed.
//
// Handshake: VALUE_IN is consumed on every rising edge where VALID_IN=1. There
// is no ready/backpressure because the multiplier cannot stall. VALID_OUT is a
// one-cycle pulse that qualifies VALUE_OUT and SAT_OUT. VALUE_OUT holds the
// last result between pulses.
//
// Ports:
//   CLK        clock, all logic on the rising edge
//   RST        synchronous active-high reset, overrides every other input
//   VALUE_IN   signed product term
//   VALID_IN   qualifier for VALUE_IN, one term per cycle
//   BIAS_IN    signed bias, used only with the first term of a sequence
//   CLEAR_IN   aborts the partial sum; wins over a coincident term
//   VALUE_OUT  signed saturated result
//   VALID_OUT  one-cycle result strobe
//   SAT_OUT    result was clipped (qualified by VALID_OUT)
//   BUSY_OUT   a partial sequence is in progress (registered)
// -----------------------------------------------------------------------------
module fixed_point_acc #(
    parameter int WIDTH     = 8,
    parameter int NUM_TERMS = 4,
    parameter int ACC_WIDTH = WIDTH + $clog2(NUM_TERMS + 1)
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [WIDTH-1:0] VALUE_IN,
    input  logic             VALID_IN,
    input  logic [WIDTH-1:0] BIAS_IN,
    input  logic             CLEAR_IN,
    output logic [WIDTH-1:0] VALUE_OUT,
    output logic             VALID_OUT,
    output logic             SAT_OUT,
    output logic             BUSY_OUT
);

    // A one-term sequence still needs a 1-bit counter; it simply stays at 0.
    localparam int CNT_W = (NUM_TERMS > 1) ? $clog2(NUM_TERMS) : 1;
    localparam logic [CNT_W-1:0] LAST_TERM = CNT_W'(NUM_TERMS - 1);

    localparam logic signed [ACC_WIDTH-1:0] SAT_MAX = ACC_WIDTH'((1 << (WIDTH - 1)) - 1);
    localparam logic signed [ACC_WIDTH-1:0] SAT_MIN = ~SAT_MAX;

    logic signed [ACC_WIDTH-1:0] acc;
    logic        [CNT_W-1:0]     count;

    logic signed [ACC_WIDTH-1:0] term_ext;
    logic signed [ACC_WIDTH-1:0] bias_ext;
    logic signed [ACC_WIDTH-1:0] sum_next;
    logic                        sat_hi;
    logic                        sat_lo;
    logic        [WIDTH-1:0]     sat_value;
    logic                        last_term;
    logic                        take_term;
    logic        [CNT_W-1:0]     count_next;
    logic signed [ACC_WIDTH-1:0] acc_next;

    assign term_ext = {{(ACC_WIDTH - WIDTH){VALUE_IN[WIDTH-1]}}, VALUE_IN};
    assign bias_ext = {{(ACC_WIDTH - WIDTH){BIAS_IN[WIDTH-1]}}, BIAS_IN};

    // The first term of a sequence restarts from the bias rather than from acc.
    // So acc never has to be cleared between back-to-back sequences.
    assign sum_next = (count == '0) ? (bias_ext + term_ext) : (acc + term_ext);

    // Only the final full-precision sum is clipped. Guard bits absorb any
    // intermediate excursion.
    assign sat_hi = (sum_next > SAT_MAX);
    assign sat_lo = (sum_next < SAT_MIN);

    always_comb begin
        sat_value = sum_next[WIDTH-1:0];
        if (sat_hi) begin
            sat_value = SAT_MAX[WIDTH-1:0];
        end else if (sat_lo) begin
            sat_value = SAT_MIN[WIDTH-1:0];
        end
    end

    assign take_term = VALID_IN && !CLEAR_IN;
    assign last_term = take_term && (count == LAST_TERM);

    always_comb begin
        count_next = count;
        acc_next   = acc;
        if (CLEAR_IN) begin
            count_next = '0;
            acc_next   = '0;
        end else if (VALID_IN) begin
            acc_next = sum_next;
            if (count == LAST_TERM) begin
                count_next = '0;
            end else begin
                count_next = count + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            acc       <= '0;
            count     <= '0;
            VALUE_OUT <= '0;
            VALID_OUT <= 1'b0;
            SAT_OUT   <= 1'b0;
            BUSY_OUT  <= 1'b0;
        end else begin
            acc       <= acc_next;
            count     <= count_next;
            BUSY_OUT  <= (count_next != '0);
            VALID_OUT <= last_term;
            SAT_OUT   <= last_term && (sat_hi || sat_lo);
            if (last_term) begin
                VALUE_OUT <= sat_value;
            end
        end
    end

endmodule
